// File: rtl/prog_seq_ctrl.sv
// Program sequencer: PC, branches, call/return stack.
// Sticky halt and stack-fault status; all outputs registered.
//
// Ports:
//   clk, reset       rising-edge clock, sync active-high reset
//   stall, halt      hold this cycle / stop permanently
//   zero             ALU zero flag
//   branch_zero      branch when zero=1
//   branch_nz        branch when zero=0
//   branch_always    unconditional branch
//   call, ret        push+jump / pop+jump
//   rel              destination: 1 = PC+offset, 0 = target
//   target, offset   absolute / signed relative destination
//   PC               current program counter
//   halted, fault    sticky status
//   fault_code       00 none, 01 overflow, 10 underflow
//   sp               number of stack entries
module prog_seq_ctrl #(
  parameter int PC_W        = 10,
  parameter int TGT_W       = 8,
  parameter int OFF_W       = 8,
  parameter int STACK_DEPTH = 4,
  localparam int SP_W  = $clog2(STACK_DEPTH + 1),
  localparam int IDX_W = (STACK_DEPTH > 1) ?
                         $clog2(STACK_DEPTH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              halt,
  input  logic              zero,
  input  logic              branch_zero,
  input  logic              branch_nz,
  input  logic              branch_always,
  input  logic              call,
  input  logic              ret,
  input  logic              rel,
  input  logic [TGT_W-1:0]  target,
  input  logic [OFF_W-1:0]  offset,
  output logic [PC_W-1:0]   PC,
  output logic              halted,
  output logic              fault,
  output logic [1:0]        fault_code,
  output logic [SP_W-1:0]   sp
);

  localparam logic [1:0] FC_NONE = 2'b00;
  localparam logic [1:0] FC_OVF  = 2'b01;
  localparam logic [1:0] FC_UNF  = 2'b10;

  logic [PC_W-1:0]  pc_q, pc_d;
  logic [SP_W-1:0]  sp_q, sp_d;
  logic             halted_q, halted_d;
  logic             fault_q, fault_d;
  logic [1:0]       code_q, code_d;
  logic [PC_W-1:0]  stack_q [STACK_DEPTH];

  logic [PC_W-1:0]  off_ext;
  logic [PC_W-1:0]  tgt_ext;
  logic [PC_W-1:0]  seq;
  logic [PC_W-1:0]  dest;
  logic             taken;
  logic             push_en;
  logic [IDX_W-1:0] push_idx;
  logic [IDX_W-1:0] pop_idx;

  // Signed cast sign-extends the offset; target zero-extends.
  assign off_ext  = PC_W'($signed(offset));
  assign tgt_ext  = PC_W'(target);
  assign seq      = pc_q + PC_W'(1);
  assign dest     = rel ? pc_q + off_ext : tgt_ext;
  assign taken    = branch_always |
                    (branch_zero & zero) |
                    (branch_nz & ~zero);
  assign push_idx = IDX_W'(sp_q);
  assign pop_idx  = IDX_W'(sp_q - SP_W'(1));

  always_comb begin
    pc_d     = pc_q;
    sp_d     = sp_q;
    halted_d = halted_q;
    fault_d  = fault_q;
    code_d   = code_q;
    push_en  = 1'b0;
    if (!halted_q) begin
      if (halt) begin
        halted_d = 1'b1;
      end else if (!stall) begin
        if (ret) begin
          if (sp_q != '0) begin
            pc_d = stack_q[pop_idx];
            sp_d = sp_q - SP_W'(1);
          end else begin
            fault_d  = 1'b1;
            code_d   = FC_UNF;
            halted_d = 1'b1;
          end
        end else if (call) begin
          if (sp_q != SP_W'(STACK_DEPTH)) begin
            push_en = 1'b1;
            sp_d    = sp_q + SP_W'(1);
            pc_d    = dest;
          end else begin
            fault_d  = 1'b1;
            code_d   = FC_OVF;
            halted_d = 1'b1;
          end
        end else if (taken) begin
          pc_d = dest;
        end else begin
          pc_d = seq;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= '0;
      sp_q     <= '0;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
      code_q   <= FC_NONE;
    end else begin
      pc_q     <= pc_d;
      sp_q     <= sp_d;
      halted_q <= halted_d;
      fault_q  <= fault_d;
      code_q   <= code_d;
    end
  end

  // Contents need no reset: sp alone defines validity.
  always_ff @(posedge clk) begin
    if (!reset && push_en) begin
      stack_q[push_idx] <= seq;
    end
  end

  assign PC         = pc_q;
  assign sp         = sp_q;
  assign halted     = halted_q;
  assign fault      = fault_q;
  assign fault_code = code_q;

endmodule

// File: tb/tb_prog_seq_ctrl.sv
// Bench for prog_seq_ctrl: directed scenarios plus
// randomized traffic against a queue-based model.
module tb_prog_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset, stall, halt, zero;
  logic       branch_zero, branch_nz, branch_always;
  logic       call, ret, rel;
  logic [7:0] target, offset;
  logic [9:0] PC;
  logic       halted, fault;
  logic [1:0] fault_code;
  logic [2:0] sp;

  int cmp_n = 0;
  int err_n = 0;

  int m_pc;
  int m_stack[$];
  bit m_halted;
  bit m_fault;
  int m_code;

  prog_seq_ctrl dut (
    .clk(clk), .reset(reset), .stall(stall),
    .halt(halt), .zero(zero),
    .branch_zero(branch_zero), .branch_nz(branch_nz),
    .branch_always(branch_always),
    .call(call), .ret(ret), .rel(rel),
    .target(target), .offset(offset),
    .PC(PC), .halted(halted), .fault(fault),
    .fault_code(fault_code), .sp(sp)
  );

  always #5 clk = ~clk;

  task automatic clear_in();
    reset = 0; stall = 0; halt = 0; zero = 0;
    branch_zero = 0; branch_nz = 0; branch_always = 0;
    call = 0; ret = 0; rel = 0;
    target = 0; offset = 0;
  endtask

  function automatic int dest_of();
    int off;
    off = (offset >= 128) ? int'(offset) - 256 : int'(offset);
    if (rel) return ((m_pc + off) % 1024 + 1024) % 1024;
    return int'(target);
  endfunction

  task automatic model_step();
    bit tk;
    tk = branch_always | (branch_zero & zero) |
         (branch_nz & ~zero);
    if (reset) begin
      m_pc = 0; m_stack.delete();
      m_halted = 0; m_fault = 0; m_code = 0;
    end else if (m_halted) begin
    end else if (halt) begin
      m_halted = 1;
    end else if (stall) begin
    end else if (ret) begin
      if (m_stack.size() > 0) m_pc = m_stack.pop_back();
      else begin m_fault = 1; m_code = 2; m_halted = 1; end
    end else if (call) begin
      if (m_stack.size() < 4) begin
        m_stack.push_back((m_pc + 1) % 1024);
        m_pc = dest_of();
      end else begin
        m_fault = 1; m_code = 1; m_halted = 1;
      end
    end else if (tk) begin
      m_pc = dest_of();
    end else begin
      m_pc = (m_pc + 1) % 1024;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_in(); reset = 1; tick(); reset = 0;
  endtask

  task automatic jump_abs(input int t);
    clear_in(); branch_always = 1; target = 8'(t);
    tick(); clear_in();
  endtask

  task automatic do_call(input int t);
    clear_in(); call = 1; target = 8'(t);
    tick(); clear_in();
  endtask

  task automatic do_ret();
    clear_in(); ret = 1; tick(); clear_in();
  endtask

  task automatic test_reset();
    do_reset();
    cmp_n++;
    if (PC !== 10'd0 || sp !== 3'd0 || halted !== 1'b0 ||
        fault !== 1'b0 || fault_code !== 2'b00) begin
      err_n++;
      $display("FAIL reset_vals: PC=%0d sp=%0d h=%0b f=%0b c=%0d want 0",
               PC, sp, halted, fault, fault_code);
    end
    for (int i = 1; i <= 5; i++) begin
      tick();
      cmp_n++;
      if (PC !== 10'(i) || sp !== 3'd0 || halted !== 1'b0) begin
        err_n++;
        $display("FAIL free_run: PC=%0d sp=%0d h=%0b want PC=%0d",
                 PC, sp, halted, i);
      end
    end
  endtask

  task automatic test_relative();
    jump_abs(20);
    cmp_n++;
    if (PC !== 10'd20) begin
      err_n++; $display("FAIL abs_jump: PC=%0d want 20", PC);
    end
    branch_always = 1; rel = 1; offset = 8'hF6;
    tick(); clear_in();
    cmp_n++;
    if (PC !== 10'd10) begin
      err_n++; $display("FAIL rel_back: PC=%0d want 10", PC);
    end
    branch_always = 1; rel = 1; offset = 8'hF2;
    tick(); clear_in();
    cmp_n++;
    if (PC !== 10'd1020) begin
      err_n++; $display("FAIL rel_under: PC=%0d want 1020", PC);
    end
    branch_always = 1; rel = 1; offset = 8'd8;
    tick(); clear_in();
    cmp_n++;
    if (PC !== 10'd4) begin
      err_n++; $display("FAIL rel_wrap: PC=%0d want 4", PC);
    end
  endtask

  task automatic test_conditional();
    branch_zero = 1; zero = 0; target = 8'h30;
    tick(); clear_in();
    cmp_n++;
    if (PC !== 10'd5) begin
      err_n++; $display("FAIL bz_not_taken: PC=%0d want 5", PC);
    end
    branch_nz = 1; zero = 0; target = 8'h55;
    tick(); clear_in();
    cmp_n++;
    if (PC !== 10'h055) begin
      err_n++; $display("FAIL bnz_taken: PC=%0d want 85", PC);
    end
    branch_zero = 1; zero = 1; target = 8'h30;
    tick(); clear_in();
    cmp_n++;
    if (PC !== 10'h030) begin
      err_n++; $display("FAIL bz_taken: PC=%0d want 48", PC);
    end
    branch_nz = 1; zero = 1; target = 8'h77;
    tick(); clear_in();
    cmp_n++;
    if (PC !== 10'h031) begin
      err_n++; $display("FAIL bnz_not_taken: PC=%0d want 49", PC);
    end
  endtask

  task automatic test_call_ret();
    int tg[4] = '{40, 60, 80, 100};
    int rp[4] = '{81, 61, 41, 4};
    do_reset();
    tick(); tick(); tick();
    cmp_n++;
    if (PC !== 10'd3) begin
      err_n++; $display("FAIL call_setup: PC=%0d want 3", PC);
    end
    for (int i = 0; i < 4; i++) begin
      do_call(tg[i]);
      cmp_n++;
      if (PC !== 10'(tg[i]) || sp !== 3'(i + 1)) begin
        err_n++;
        $display("FAIL call_%0d: PC=%0d sp=%0d want PC=%0d sp=%0d",
                 i, PC, sp, tg[i], i + 1);
      end
    end
    for (int i = 0; i < 4; i++) begin
      do_ret();
      cmp_n++;
      if (PC !== 10'(rp[i]) || sp !== 3'(3 - i)) begin
        err_n++;
        $display("FAIL ret_%0d: PC=%0d sp=%0d want PC=%0d sp=%0d",
                 i, PC, sp, rp[i], 3 - i);
      end
    end
    do_call(200);
    do_ret();
    cmp_n++;
    if (PC !== 10'd5 || sp !== 3'd0) begin
      err_n++;
      $display("FAIL b2b_call_ret: PC=%0d sp=%0d want 5 0", PC, sp);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    do_call(10); do_call(20); do_call(30); do_call(40);
    do_call(99);
    cmp_n++;
    if (PC !== 10'd40 || sp !== 3'd4 || halted !== 1'b1 ||
        fault !== 1'b1 || fault_code !== 2'b01) begin
      err_n++;
      $display("FAIL overflow: PC=%0d sp=%0d h=%0b f=%0b c=%0d want 40 4 1 1 1",
               PC, sp, halted, fault, fault_code);
    end
    for (int i = 0; i < 8; i++) begin
      stall = 1'($urandom); halt = 1'($urandom);
      zero = 1'($urandom); branch_always = 1'($urandom);
      call = 1'($urandom); ret = 1'($urandom);
      rel = 1'($urandom); target = 8'($urandom);
      tick(); clear_in();
      cmp_n++;
      if (PC !== 10'd40 || sp !== 3'd4 || halted !== 1'b1 ||
          fault !== 1'b1 || fault_code !== 2'b01) begin
        err_n++;
        $display("FAIL frozen: PC=%0d sp=%0d h=%0b f=%0b c=%0d",
                 PC, sp, halted, fault, fault_code);
      end
    end
    call = 1; branch_always = 1; reset = 1;
    tick(); clear_in();
    cmp_n++;
    if (PC !== 10'd0 || sp !== 3'd0 || halted !== 1'b0 ||
        fault !== 1'b0 || fault_code !== 2'b00) begin
      err_n++;
      $display("FAIL fault_reset: PC=%0d sp=%0d h=%0b f=%0b c=%0d",
               PC, sp, halted, fault, fault_code);
    end
  endtask

  task automatic test_underflow();
    do_reset();
    jump_abs(7);
    do_ret();
    cmp_n++;
    if (PC !== 10'd7 || sp !== 3'd0 || halted !== 1'b1 ||
        fault !== 1'b1 || fault_code !== 2'b10) begin
      err_n++;
      $display("FAIL underflow: PC=%0d sp=%0d h=%0b f=%0b c=%0d want 7 0 1 1 2",
               PC, sp, halted, fault, fault_code);
    end
  endtask

  task automatic test_stall_halt();
    do_reset();
    jump_abs(12);
    do_call(50);
    stall = 1; call = 1; target = 8'd90;
    tick(); clear_in();
    cmp_n++;
    if (PC !== 10'd50 || sp !== 3'd1) begin
      err_n++;
      $display("FAIL stall_call: PC=%0d sp=%0d want 50 1", PC, sp);
    end
    stall = 1; ret = 1;
    tick(); clear_in();
    cmp_n++;
    if (PC !== 10'd50 || sp !== 3'd1) begin
      err_n++;
      $display("FAIL stall_ret: PC=%0d sp=%0d want 50 1", PC, sp);
    end
    do_ret();
    cmp_n++;
    if (PC !== 10'd13 || sp !== 3'd0) begin
      err_n++;
      $display("FAIL stack_kept: PC=%0d sp=%0d want 13 0", PC, sp);
    end
    halt = 1; branch_always = 1; target = 8'd200;
    tick(); clear_in();
    cmp_n++;
    if (PC !== 10'd13 || halted !== 1'b1 || fault !== 1'b0) begin
      err_n++;
      $display("FAIL halt_br: PC=%0d h=%0b f=%0b want 13 1 0",
               PC, halted, fault);
    end
    tick();
    cmp_n++;
    if (PC !== 10'd13 || halted !== 1'b1) begin
      err_n++;
      $display("FAIL halt_hold: PC=%0d h=%0b want 13 1", PC, halted);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 99) < 2);
      halt = ($urandom_range(0, 199) < 1);
      stall = ($urandom_range(0, 99) < 15);
      ret = ($urandom_range(0, 99) < 20);
      call = ($urandom_range(0, 99) < 22);
      zero = 1'($urandom);
      branch_zero = 1'($urandom);
      branch_nz = 1'($urandom);
      branch_always = ($urandom_range(0, 99) < 20);
      rel = 1'($urandom);
      target = 8'($urandom);
      offset = 8'($urandom);
      tick();
      cmp_n++;
      if (PC !== 10'(m_pc) || sp !== 3'(m_stack.size()) ||
          halted !== m_halted || fault !== m_fault ||
          fault_code !== 2'(m_code)) begin
        err_n++;
        $display("FAIL rand_%0d: PC=%0d sp=%0d h=%0b f=%0b c=%0d want %0d %0d %0b %0b %0d",
                 i, PC, sp, halted, fault, fault_code, m_pc,
                 m_stack.size(), m_halted, m_fault, m_code);
      end
    end
    clear_in();
  endtask

  initial begin
    m_pc = 0; m_halted = 0; m_fault = 0; m_code = 0;
    clear_in();
    test_reset();
    test_relative();
    test_conditional();
    test_call_ret();
    test_overflow();
    test_underflow();
    test_stall_halt();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             cmp_n, err_n);
    $finish;
  end

endmodule
